toggle_hs_rx: RTL and testbench
===============================

# toggle_hs_rx

Receive end of the two-phase (toggle) handshake used with our toggle-flop request generators. A sender flips `req_tgl` once per word and holds `data_in` stable. This block captures each word into a small FIFO, answers by flipping `ack_tgl`, and presents buffered words to a local consumer through a show-ahead read port. It sits between any toggle-request producer and downstream logic in the same clock domain, with no synchronizers.

## Interface
Parameters:
- `DATA_W`, 8: width of each transferred word.
- `DEPTH`, 4: number of FIFO entries. Must be a power of two, at least 2.

Ports:
- `clk`, in, 1: the only clock; all state updates on its rising edge.
- `reset`, in, 1: synchronous, active-low reset.
- `req_tgl`, in, 1: request toggle from the sender. A transfer is pending whenever `req_tgl != ack_tgl`.
- `data_in`, in, DATA_W: word offered by the sender; stable while a transfer is pending.
- `ack_tgl`, out, 1: acknowledge toggle; flips once per accepted word.
- `rd_en`, in, 1: consumer pop strobe; ignored when `valid` = 0.
- `data_out`, out, DATA_W: head-of-FIFO word; forced to 0 when `valid` = 0.
- `valid`, out, 1: FIFO is not empty.
- `full`, out, 1: FIFO holds DEPTH words.
- `count`, out, $clog2(DEPTH)+1: number of words held, from 0 to DEPTH.
- `proto_err`, out, 1: sticky flag; the sender toggled again before its previous request was acknowledged.

## Operation
- Registers: `ack_tgl`, `req_q` (`req_tgl` delayed one cycle), `proto_err`, write pointer, read pointer, `count`, storage array.
- Derived terms:
  - pending = `req_tgl ^ ack_tgl`.
  - pop = `rd_en & valid`.
  - accept = pending & (!`full` | pop).
- Handshake states, implied by the registers rather than an encoded FSM:
  - IDLE: not pending.
  - CAPTURE: pending and space available; accept happens at the next edge.
  - STALL: pending and `full` with no pop; `ack_tgl` is held and `data_in` is not sampled.
  - Transition: STALL moves to CAPTURE as soon as a pop is coincident or a slot is free.
- On accept:
  - `data_in` is written at the write pointer.
  - The write pointer increments mod DEPTH.
  - `ack_tgl` inverts.
- On pop, the read pointer increments mod DEPTH.
- `count` update: `count` += accept − pop.
  - accept and pop together leave `count` unchanged, including when `full` (push-through).
  - Pointer wrap from DEPTH−1 to 0 is silent.
- Empty FIFO:
  - `rd_en` has no effect.
  - An accept and `rd_en` in the same cycle: the word is stored, not popped. It becomes visible next cycle.
- `proto_err`:
  - Set when (`req_tgl != req_q`) & (`req_q != ack_tgl`), i.e. a new toggle arrived while the prior request was still outstanding.
  - Stays set until reset. Data behaviour is otherwise unchanged, and the lost word is not recovered.
- Reset (`reset` = 0 at an edge) clears all of the following regardless of activity in progress:
  - `ack_tgl` = 0, `req_q` = 0.
  - Both pointers = 0, `count` = 0, `valid` = 0, `full` = 0.
  - `proto_err` = 0, `data_out` = 0.
  - Storage contents are don't-care.
- After reset, `req_tgl` = 1 is treated as a pending transfer. Senders are reset with the same `reset`.

## Timing
- Accept latency: a request made visible before edge N, with space available, is accepted at edge N.
  - `ack_tgl`, `count`, `valid` and `full` all update at edge N.
  - The word is at `data_out` from edge N if the FIFO was empty.
- Throughput: with a registered sender (sender reacts to `ack_tgl` at N+1), at most one word per two cycles.
- A pop at edge N exposes the next head word, or `valid` = 0, immediately after N.
- `valid`, `full`, `count` and `proto_err` are registered, or decoded only from registers.
- `data_out` is a combinational read of the head entry, gated by `valid`.
- Stalls:
  - No combinational path from `rd_en` to `ack_tgl`; a stall releases at the same edge as the pop.
  - `ack_tgl` never toggles twice in consecutive cycles unless `req_tgl` toggles in between.

## Test plan
- **Reset:** hold `reset` = 0 for 2 cycles with `req_tgl` = 0 → `ack_tgl` = 0, `valid` = 0, `full` = 0, `count` = 0, `proto_err` = 0, `data_out` = 0.
- **Single transfer:** `data_in` = 8'hA5, `req_tgl` 0→1 → at the next edge `ack_tgl` = 1, `count` = 1, `valid` = 1, `data_out` = A5. Then one `rd_en` pulse → `valid` = 0, `count` = 0, `data_out` = 0.
- **Fill and stall:** with `rd_en` = 0, send 11, 22, 33, 44 → `full` = 1, `count` = 4. Toggle again with 55 → `ack_tgl` is held for 5 cycles and `count` stays 4. Assert `rd_en` for 1 cycle → 55 is accepted at that edge, `ack_tgl` flips, `count` = 4, `data_out` = 22.
- **Drain with wrap:** pop continuously → 22, 33, 44, 55 appear in order. `valid` falls after 55 and both pointers have wrapped past index 3.
- **Protocol error:** while `full`, toggle `req_tgl` on two consecutive cycles → `proto_err` = 1 and remains 1 through 10 further idle cycles. A following `reset` → `proto_err` = 0.
- **Reset mid-operation:** with `count` = 3, assert `reset` for 1 cycle while `req_tgl` = 1 → all outputs return to their reset values. On the first edge after release, the pending request is accepted: `ack_tgl` = 1, `count` = 1.

Source files
------------

// File: rtl/toggle_hs_rx.sv
// Receive side of a two-phase (toggle) handshake: captures each offered word
// into a small FIFO, acknowledges by flipping ack_tgl, and exposes a show-ahead read port.
module toggle_hs_rx #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       req_tgl,
   input  logic [DATA_W-1:0]          data_in,
   output logic                       ack_tgl,
   input  logic                       rd_en,
   output logic [DATA_W-1:0]          data_out,
   output logic                       valid,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       proto_err
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   // Handshake phase, decoded from registers and the live request/pop
   typedef enum logic [1:0] {
      HS_IDLE    = 2'd0,
      HS_CAPTURE = 2'd1,
      HS_STALL   = 2'd2
   } hs_state_t;

   hs_state_t          hs_state;

   logic               ack_q,   ack_d;
   logic               req_q,   req_d;
   logic               err_q,   err_d;
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]      count_q, count_d;
   logic [DATA_W-1:0]  mem [DEPTH];

   logic               pending;
   logic               pop;
   logic               accept;
   logic               is_full;
   logic               is_valid;

   assign is_full  = (count_q == CW'(DEPTH));
   assign is_valid = (count_q != CW'(0));
   assign pending  = req_tgl ^ ack_q;
   assign pop      = rd_en & is_valid;

   // Phase decode: a pop on a full FIFO frees the slot in the same edge
   always_comb begin
      hs_state = HS_IDLE;
      if (pending) begin
         if (is_full && !pop) begin
            hs_state = HS_STALL;
         end else begin
            hs_state = HS_CAPTURE;
         end
      end
   end

   assign accept = (hs_state == HS_CAPTURE);

   // Next-state for control registers
   always_comb begin
      ack_d    = ack_q;
      req_d    = req_tgl;
      err_d    = err_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;

      if (accept) begin
         ack_d    = ~ack_q;
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (accept && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !accept) begin
         count_d = count_q - CW'(1);
      end

      // A second toggle arriving while the previous one is still outstanding
      if ((req_tgl != req_q) && (req_q != ack_q)) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         ack_q    <= 1'b0;
         req_q    <= 1'b0;
         err_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         ack_q    <= ack_d;
         req_q    <= req_d;
         err_q    <= err_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; contents are only observable while counted
   always_ff @(posedge clk) begin
      if (reset && accept) begin
         mem[wr_ptr_q] <= data_in;
      end
   end

   assign ack_tgl   = ack_q;
   assign proto_err = err_q;
   assign count     = count_q;
   assign valid     = is_valid;
   assign full      = is_full;
   assign data_out  = is_valid ? mem[rd_ptr_q] : '0;

endmodule

// File: tb/tb_toggle_hs_rx.sv
// Scoreboard bench for toggle_hs_rx: a toggle sender pushes expected words,
// consumer pops compare them against data_out.
module tb_toggle_hs_rx;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned CW     = $clog2(DEPTH) + 1;

   logic              clk = 1'b0;
   logic              reset;
   logic              req_tgl;
   logic [DATA_W-1:0] data_in;
   logic              ack_tgl;
   logic              rd_en;
   logic [DATA_W-1:0] data_out;
   logic              valid;
   logic              full;
   logic [CW-1:0]     count;
   logic              proto_err;

   int unsigned errors = 0;
   int unsigned checks = 0;
   logic [DATA_W-1:0] sb_q[$];

   toggle_hs_rx #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_tgl   (req_tgl),
      .data_in   (data_in),
      .ack_tgl   (ack_tgl),
      .rd_en     (rd_en),
      .data_out  (data_out),
      .valid     (valid),
      .full      (full),
      .count     (count),
      .proto_err (proto_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one word; expect acceptance at the very next edge
   task automatic send(input logic [DATA_W-1:0] d, input bit push);
      int lat;
      data_in = d;
      req_tgl = ~req_tgl;
      if (push) sb_q.push_back(d);
      lat = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         lat++;
         if (ack_tgl == req_tgl) break;
      end
      check("ack_follows_req", 32'(ack_tgl), 32'(req_tgl));
      check("accept_latency", 32'(lat), 32'd1);
   endtask

   // Compare head with scoreboard, then pop it
   task automatic pop_cmp();
      logic [DATA_W-1:0] exp;
      check("pop_valid", 32'(valid), 32'd1);
      check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      exp = (sb_q.size() != 0) ? sb_q.pop_front() : '0;
      check("data_out", 32'(data_out), 32'(exp));
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_ack"},   32'(ack_tgl),   32'd0);
      check({tag, "_valid"}, 32'(valid),     32'd0);
      check({tag, "_full"},  32'(full),      32'd0);
      check({tag, "_count"}, 32'(count),     32'd0);
      check({tag, "_perr"},  32'(proto_err), 32'd0);
      check({tag, "_dout"},  32'(data_out),  32'd0);
   endtask

   initial begin
      reset   = 1'b0;
      req_tgl = 1'b0;
      data_in = '0;
      rd_en   = 1'b0;

      // Reset
      step();
      step();
      check_reset_vals("rst");
      reset = 1'b1;
      step();

      // Single transfer and pop to empty
      send(8'hA5, 1'b1);
      check("single_count", 32'(count), 32'd1);
      check("single_valid", 32'(valid), 32'd1);
      pop_cmp();
      check("single_empty_valid", 32'(valid), 32'd0);
      check("single_empty_count", 32'(count), 32'd0);
      check("single_empty_dout",  32'(data_out), 32'd0);

      // Fill and stall
      send(8'h11, 1'b1);
      send(8'h22, 1'b1);
      send(8'h33, 1'b1);
      send(8'h44, 1'b1);
      check("fill_full",  32'(full),  32'd1);
      check("fill_count", 32'(count), 32'd4);
      data_in = 8'h55;
      req_tgl = ~req_tgl;
      sb_q.push_back(8'h55);
      for (int i = 0; i < 5; i++) begin
         step();
         check("stall_ack_held", 32'(ack_tgl != req_tgl), 32'd1);
         check("stall_count", 32'(count), 32'd4);
      end
      pop_cmp();
      check("release_ack", 32'(ack_tgl), 32'(req_tgl));
      check("release_count", 32'(count), 32'd4);
      check("release_head", 32'(data_out), 32'h22);

      // Drain with wrap
      while (sb_q.size() != 0) pop_cmp();
      check("drain_valid", 32'(valid), 32'd0);
      check("drain_count", 32'(count), 32'd0);

      // Accept into empty FIFO with coincident rd_en: word is kept
      rd_en = 1'b1;
      send(8'h5A, 1'b1);
      rd_en = 1'b0;
      check("empty_rd_count", 32'(count), 32'd1);
      check("empty_rd_valid", 32'(valid), 32'd1);
      pop_cmp();
      check("empty_rd_after", 32'(valid), 32'd0);

      // Protocol error while full
      send(8'hC1, 1'b1);
      send(8'hC2, 1'b1);
      send(8'hC3, 1'b1);
      send(8'hC4, 1'b1);
      data_in = 8'hEE;
      req_tgl = ~req_tgl;
      step();
      req_tgl = ~req_tgl;
      step();
      check("perr_set", 32'(proto_err), 32'd1);
      for (int i = 0; i < 10; i++) step();
      check("perr_sticky", 32'(proto_err), 32'd1);
      check("perr_count", 32'(count), 32'd4);
      check("perr_head", 32'(data_out), 32'(sb_q[0]));
      reset   = 1'b0;
      req_tgl = 1'b0;
      step();
      reset = 1'b1;
      sb_q.delete();
      check_reset_vals("perr_rst");

      // Reset mid-operation with a request high
      send(8'h01, 1'b1);
      send(8'h02, 1'b1);
      send(8'h03, 1'b1);
      check("mid_count", 32'(count), 32'd3);
      check("mid_req_high", 32'(req_tgl), 32'd1);
      data_in = 8'h99;
      reset   = 1'b0;
      step();
      check_reset_vals("mid_rst");
      reset = 1'b1;
      sb_q.delete();
      sb_q.push_back(8'h99);
      step();
      check("post_rst_ack", 32'(ack_tgl), 32'd1);
      check("post_rst_count", 32'(count), 32'd1);
      pop_cmp();
      check("post_rst_empty", 32'(valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
